// File: rtl/ifft_conj_ctrl.sv
// Conjugation wrapper that lets a forward-only FFT core also perform IFFTs.
// Each input frame is tagged with a mode at its first sample. IFFT frames get
// their imaginary part negated on the way in; on the way out they are negated
// again and scaled by 1/N. The mode tags ride alongside the core in a 2-deep
// queue, since the core holds at most two frames in flight.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   I_IDLE   | waiting for the first sample of a frame (in_cnt = 0)
//   I_LOAD   | mid-frame on the input side; mode_in is ignored here
//   O_IDLE   | waiting for the first core result of a frame (out_cnt = 0)
//   O_STREAM | mid-frame on the output side, out_mode fixed for the frame
module ifft_conj_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 64,
  parameter int LOG2N      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_in,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  fft_in_valid,
  output logic [DATA_WIDTH-1:0] fft_in_r,
  output logic [DATA_WIDTH-1:0] fft_in_i,
  input  logic                  fft_out_valid,
  input  logic [DATA_WIDTH-1:0] fft_out_r,
  input  logic [DATA_WIDTH-1:0] fft_out_i,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic {I_IDLE, I_LOAD} in_state_e;
  typedef enum logic {O_IDLE, O_STREAM} out_state_e;

  // Two's complement negation clamped so the most negative value maps to max.
  function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] x);
    return (x == S_MIN) ? S_MAX : -x;
  endfunction

  in_state_e             in_state_q;
  logic [CW-1:0]         in_cnt_q;
  logic                  frame_mode_q;
  logic                  fft_in_valid_q;
  logic [DATA_WIDTH-1:0] fft_in_r_q;
  logic [DATA_WIDTH-1:0] fft_in_i_q;

  out_state_e            out_state_q;
  logic [CW-1:0]         out_cnt_q;
  logic                  out_mode_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_r_q;
  logic [DATA_WIDTH-1:0] out_i_q;
  logic                  out_last_q;

  logic [1:0]            q_mem_q, q_mem_d;
  logic [1:0]            q_cnt_q, q_cnt_d;
  logic                  err_q, err_d;

  logic                  push, pop, push_ok, pop_ok, wr_idx;
  logic                  in_eff_mode, head_mode, out_eff_mode;
  logic signed [DATA_WIDTH-1:0] ifft_r, ifft_i;

  // The first sample of a frame is conjugated according to mode_in directly,
  // because frame_mode is only being captured on that same edge.
  assign in_eff_mode  = (in_state_q == I_IDLE) ? mode_in : frame_mode_q;
  assign push         = in_valid && (in_state_q == I_IDLE);
  assign pop          = fft_out_valid && (out_state_q == O_IDLE);
  assign head_mode    = (q_cnt_q != 2'd0) ? q_mem_q[0] : 1'b0;
  assign out_eff_mode = (out_state_q == O_IDLE) ? head_mode : out_mode_q;

  assign ifft_r = $signed(fft_out_r) >>> LOG2N;
  assign ifft_i = $signed(neg_sat(fft_out_i)) >>> LOG2N;

  // Input FSM: frame counting, mode capture and conjugation towards the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_q     <= I_IDLE;
      in_cnt_q       <= '0;
      frame_mode_q   <= 1'b0;
      fft_in_valid_q <= 1'b0;
      fft_in_r_q     <= '0;
      fft_in_i_q     <= '0;
    end else begin
      fft_in_valid_q <= in_valid;
      if (in_valid) begin
        fft_in_r_q <= in_r;
        fft_in_i_q <= in_eff_mode ? neg_sat(in_i) : in_i;
        if (in_state_q == I_IDLE) begin
          frame_mode_q <= mode_in;
        end
        if (in_cnt_q == LAST_IDX) begin
          in_cnt_q   <= '0;
          in_state_q <= I_IDLE;
        end else begin
          in_cnt_q   <= in_cnt_q + CW'(1);
          in_state_q <= I_LOAD;
        end
      end
    end
  end

  // Mode queue next state: pop happens before push so a full queue can
  // accept a new frame in the cycle its oldest entry leaves.
  always_comb begin
    q_mem_d = q_mem_q;
    q_cnt_d = q_cnt_q;
    err_d   = err_q;
    pop_ok  = pop && (q_cnt_q != 2'd0);
    push_ok = push && ((q_cnt_q != 2'd2) || pop_ok);
    wr_idx  = pop_ok ? (q_cnt_q == 2'd2) : (q_cnt_q == 2'd1);
    if (pop && (q_cnt_q == 2'd0)) begin
      err_d = 1'b1;
    end
    if (push && !push_ok) begin
      err_d = 1'b1;
    end
    if (pop_ok) begin
      q_mem_d[0] = q_mem_q[1];
    end
    if (push_ok) begin
      q_mem_d[wr_idx] = frame_mode_in_sel();
    end
    case ({push_ok, pop_ok})
      2'b10:   q_cnt_d = q_cnt_q + 2'd1;
      2'b01:   q_cnt_d = q_cnt_q - 2'd1;
      default: q_cnt_d = q_cnt_q;
    endcase
  end

  // Mode pushed with a new frame is the one sampled at its first sample.
  function automatic logic frame_mode_in_sel();
    return mode_in;
  endfunction

  // Mode queue and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_mem_q <= '0;
      q_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      q_mem_q <= q_mem_d;
      q_cnt_q <= q_cnt_d;
      err_q   <= err_d;
    end
  end

  // Output FSM: frame counting, mode pop, de-conjugation and 1/N scaling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state_q <= O_IDLE;
      out_cnt_q   <= '0;
      out_mode_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= fft_out_valid;
      out_last_q  <= fft_out_valid && (out_cnt_q == LAST_IDX);
      if (fft_out_valid) begin
        if (out_eff_mode) begin
          out_r_q <= ifft_r;
          out_i_q <= ifft_i;
        end else begin
          out_r_q <= fft_out_r;
          out_i_q <= fft_out_i;
        end
        if (out_state_q == O_IDLE) begin
          out_mode_q <= head_mode;
        end
        if (out_cnt_q == LAST_IDX) begin
          out_cnt_q   <= '0;
          out_state_q <= O_IDLE;
        end else begin
          out_cnt_q   <= out_cnt_q + CW'(1);
          out_state_q <= O_STREAM;
        end
      end
    end
  end

  assign fft_in_valid = fft_in_valid_q;
  assign fft_in_r     = fft_in_r_q;
  assign fft_in_i     = fft_in_i_q;
  assign out_valid    = out_valid_q;
  assign out_r        = out_r_q;
  assign out_i        = out_i_q;
  assign out_last     = out_last_q;
  assign err          = err_q;
  assign busy         = (in_state_q == I_LOAD) || (q_cnt_q != 2'd0) ||
                        (out_state_q == O_STREAM);

endmodule

// File: tb/tb_ifft_conj_ctrl.sv
// Bench for ifft_conj_ctrl: directed frame scenarios with random sample data,
// compared every cycle against a frame-level model (mode queue, sample
// indices, conjugate-and-divide arithmetic).
module tb_ifft_conj_ctrl;
  localparam int W     = 32;
  localparam int N     = 64;
  localparam int LOG2N = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode_in, in_valid, fft_out_valid;
  logic [W-1:0] in_r, in_i, fft_out_r, fft_out_i;
  logic         fft_in_valid, out_valid, out_last, busy, err;
  logic [W-1:0] fft_in_r, fft_in_i, out_r, out_i;

  always #5 clk = ~clk;

  ifft_conj_ctrl #(.DATA_WIDTH(W), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in),
    .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .fft_in_valid(fft_in_valid), .fft_in_r(fft_in_r), .fft_in_i(fft_in_i),
    .fft_out_valid(fft_out_valid), .fft_out_r(fft_out_r), .fft_out_i(fft_out_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_last(out_last),
    .busy(busy), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit           mq[$];
  int           in_idx, out_idx;
  bit           cur_in_mode, cur_out_mode, exp_err;
  logic         exp_fiv, exp_ov, exp_last;
  logic [W-1:0] exp_fir, exp_fii, exp_or, exp_oi;

  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
    longint v;
    v = -longint'($signed(x));
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v[W-1:0];
  endfunction

  // floor(x / N) done with plain integer division
  function automatic logic [W-1:0] fdiv(input logic [W-1:0] x);
    longint v, q;
    v = longint'($signed(x));
    q = v / N;
    if ((v % N) != 0 && v < 0) q = q - 1;
    return q[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk1("fft_in_valid", fft_in_valid, exp_fiv);
    chk ("fft_in_r", fft_in_r, exp_fir);
    chk ("fft_in_i", fft_in_i, exp_fii);
    chk1("out_valid", out_valid, exp_ov);
    chk ("out_r", out_r, exp_or);
    chk ("out_i", out_i, exp_oi);
    chk1("out_last", out_last, exp_last);
    chk1("busy", busy, (in_idx != 0) || (mq.size() != 0) || (out_idx != 0));
    chk1("err", err, exp_err);
  endtask

  task automatic reset_model();
    mq.delete();
    in_idx = 0; out_idx = 0;
    cur_in_mode = 1'b0; cur_out_mode = 1'b0; exp_err = 1'b0;
    exp_fiv = 1'b0; exp_ov = 1'b0; exp_last = 1'b0;
    exp_fir = '0; exp_fii = '0; exp_or = '0; exp_oi = '0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; mode_in = 1'b0; in_r = '0; in_i = '0;
    fft_out_valid = 1'b0; fft_out_r = '0; fft_out_i = '0;
    rst = 1'b0;
    reset_model();
    #2;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;
  endtask

  // one clock: drive both streams, advance the model, check all outputs
  task automatic cycle(input bit iv, input bit md, input logic [W-1:0] ir, input logic [W-1:0] ii,
                       input bit ov, input logic [W-1:0] orr, input logic [W-1:0] oi);
    in_valid = iv; mode_in = md; in_r = ir; in_i = ii;
    fft_out_valid = ov; fft_out_r = orr; fft_out_i = oi;
    exp_ov   = ov;
    exp_last = 1'b0;
    if (ov) begin
      if (out_idx == 0) begin
        if (mq.size() == 0) begin
          exp_err = 1'b1;
          cur_out_mode = 1'b0;
        end else begin
          cur_out_mode = mq.pop_front();
        end
      end
      if (cur_out_mode) begin
        exp_or = fdiv(orr);
        exp_oi = fdiv(neg_sat(oi));
      end else begin
        exp_or = orr;
        exp_oi = oi;
      end
      exp_last = (out_idx == N - 1);
      out_idx  = (out_idx + 1) % N;
    end
    exp_fiv = iv;
    if (iv) begin
      if (in_idx == 0) begin
        cur_in_mode = md;
        if (mq.size() < 2) mq.push_back(md);
        else exp_err = 1'b1;
      end
      exp_fir = ir;
      exp_fii = cur_in_mode ? neg_sat(ii) : ii;
      in_idx  = (in_idx + 1) % N;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  // input samples [from, to) of a frame; mode_in flips once sample toggle_at is reached
  task automatic load_samples(input bit md, input int from, input int to, input int toggle_at, input bit gaps);
    int k;
    bit v, m;
    k = from;
    while (k < to) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      m = (k >= toggle_at) ? ~md : md;
      cycle(v, m, $urandom, $urandom, 1'b0, '0, '0);
      if (v) k++;
    end
  endtask

  task automatic unload_samples(input int from, input int to, input bit gaps);
    int k;
    bit v;
    k = from;
    while (k < to) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(1'b0, 1'($urandom_range(0, 1)), '0, '0, v, $urandom, $urandom);
      if (v) k++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b0;
    do_reset();

    // IFFT frame: conjugate in, conjugate and divide by N out; mode_in flips mid-frame
    cycle(1'b1, 1'b1, 32'd5, -32'sd7, 1'b0, '0, '0);
    chk("ifft_fin_r0", fft_in_r, 32'd5);
    chk("ifft_fin_i0", fft_in_i, 32'd7);
    load_samples(1'b1, 1, N, 20, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 32'd640, -32'sd128);
    chk("ifft_out_r0", out_r, 32'd10);
    chk("ifft_out_i0", out_i, 32'd2);
    unload_samples(1, N, 1'b0);
    idle(2);
    chk1("idle_busy", busy, 1'b0);

    // saturation on both negations and floor rounding, with gaps
    cycle(1'b1, 1'b1, $urandom, 32'h8000_0000, 1'b0, '0, '0);
    chk("sat_fin_i", fft_in_i, 32'h7fff_ffff);
    load_samples(1'b1, 1, N, N, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 32'hffff_ffff, 32'd0);
    chk("floor_out_r", out_r, 32'hffff_ffff);
    chk("zero_out_i", out_i, 32'd0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 32'd0, 32'h8000_0000);
    chk("sat_out_i", out_i, 32'h01ff_ffff);
    unload_samples(2, N, 1'b1);

    // FFT frame with mode_in toggled at sample 10, then an IFFT frame back-to-back
    load_samples(1'b0, 0, N, 10, 1'b0);
    load_samples(1'b1, 0, N, N, 1'b0);
    chk1("two_queued_busy", busy, 1'b1);
    chk1("two_queued_err", err, 1'b0);
    // third frame enters while the first leaves: full queue push+pop together
    for (int k = 0; k < 2 * N; k++)
      cycle(k < N, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1, $urandom, $urandom);
    unload_samples(0, N, 1'b0);
    chk1("no_overflow_err", err, 1'b0);

    // overflow: three frames loaded with nothing drained
    load_samples(1'b0, 0, N, N, 1'b0);
    load_samples(1'b1, 0, N, N, 1'b0);
    chk1("pre_overflow_err", err, 1'b0);
    load_samples(1'b1, 0, N, N, 1'b0);
    chk1("overflow_err", err, 1'b1);
    unload_samples(0, N, 1'b0);
    unload_samples(0, N, 1'b0);
    unload_samples(0, N, 1'b0);  // queue empty here: passes through as FFT
    chk1("sticky_err", err, 1'b1);

    // reset mid-frame, then a clean frame counts from index 0
    load_samples(1'b1, 0, 30, N, 1'b0);
    do_reset();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    load_samples(1'b0, 0, N, N, 1'b0);
    unload_samples(0, N - 1, 1'b0);
    chk1("before_last", out_last, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 32'd640, -32'sd128);
    chk1("last_after_rst", out_last, 1'b1);
    chk("fft_pass_r", out_r, 32'd640);
    chk("fft_pass_i", out_i, -32'sd128);
    idle(1);
    chk1("final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
